// File: rtl/mar_burst_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mar_burst_pkg
// Purpose  : Shared FSM encodings and default widths for the SAP-II MAR burst.
// Revision : 1.0 - initial release
// ============================================================================
package mar_burst_pkg;

    localparam int c_ADDR_W_DEF    = 16;
    localparam int c_LEN_W_DEF     = 3;
    localparam int c_WRAP_BITS_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BURST  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mar_burst_if.sv
`default_nettype none
// ============================================================================
// Module   : mar_burst_if
// Purpose  : WBUS/controller and RAM-side handshake bundle for mar_burst.
// Revision : 1.0 - initial release
// ============================================================================
interface mar_burst_if
    import mar_burst_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W_DEF,
    parameter int LEN_W  = c_LEN_W_DEF
);
    logic [ADDR_W-1:0] WBUS;
    logic              nLw;
    logic              nRd;
    logic [LEN_W-1:0]  LEN;
    logic              MEM_ACK;
    logic [ADDR_W-1:0] address;
    logic              MEM_REQ;
    logic              BUSY;
    logic              DONE;

    modport slave (
        input  WBUS, nLw, nRd, LEN, MEM_ACK,
        output address, MEM_REQ, BUSY, DONE
    );

    modport master (
        output WBUS, nLw, nRd, LEN, MEM_ACK,
        input  address, MEM_REQ, BUSY, DONE
    );
endinterface
`default_nettype wire

// File: rtl/mar_burst_addr_inc.sv
`default_nettype none
// ============================================================================
// Module   : mar_addr_inc
// Purpose  : Next-address logic; linear, or aligned wrap when MAR_WRAP_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module mar_addr_inc
    import mar_burst_pkg::*;
#(
    parameter int ADDR_W    = c_ADDR_W_DEF,
    parameter int WRAP_BITS = c_WRAP_BITS_DEF
) (
    input  wire logic [ADDR_W-1:0] i_addr,
    output logic      [ADDR_W-1:0] o_next
);

    generate
        if (WRAP_BITS < 1 || WRAP_BITS > ADDR_W) begin : g_bad_wrap
            $error("mar_addr_inc: WRAP_BITS out of range");
        end
    endgenerate

`ifdef MAR_WRAP_EN
    generate
        if (WRAP_BITS == ADDR_W) begin : g_wrap_full
            assign o_next = i_addr + ADDR_W'(1);
        end else begin : g_wrap_win
            // Only the window bits count; the aligned upper bits stay put.
            assign o_next = {i_addr[ADDR_W-1:WRAP_BITS],
                             i_addr[WRAP_BITS-1:0] + WRAP_BITS'(1)};
        end
    endgenerate
`else
    assign o_next = i_addr + ADDR_W'(1);
`endif

endmodule
`default_nettype wire

// File: rtl/mar_burst.sv
`default_nettype none
// ============================================================================
// Module   : mar_burst
// Purpose  : SAP-II memory address register with sequential read bursts.
//            Optional aligned-wrap increment selected by MAR_WRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mar_burst
    import mar_burst_pkg::*;
#(
    parameter int ADDR_W    = c_ADDR_W_DEF,
    parameter int LEN_W     = c_LEN_W_DEF,
    parameter int WRAP_BITS = c_WRAP_BITS_DEF
) (
    input  wire logic  CLK,
    input  wire logic  nCLR,
    mar_burst_if.slave bus
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_inc;
    logic [LEN_W-1:0]  r_remain;
    logic              r_req;
    logic              r_busy;
    logic              r_done;

    mar_addr_inc #(
        .ADDR_W    (ADDR_W),
        .WRAP_BITS (WRAP_BITS)
    ) u_inc (
        .i_addr (r_addr),
        .o_next (w_addr_inc)
    );

    always_ff @(negedge CLK) begin
        if (!nCLR) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (!bus.nRd) w_state_nxt = ST_BURST;
            ST_BURST:  if (bus.MEM_ACK && r_remain == LEN_W'(1)) w_state_nxt = ST_FINISH;
            ST_FINISH: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(negedge CLK) begin
        if (!nCLR) begin
            r_addr   <= '0;
            r_remain <= '0;
            r_req    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_req  <= (w_state_nxt == ST_BURST);
            r_busy <= (w_state_nxt != ST_IDLE);
            r_done <= (w_state_nxt == ST_FINISH);
            case (r_state)
                ST_IDLE: begin
                    if (!bus.nLw) r_addr <= bus.WBUS;
                    if (!bus.nRd) r_remain <= (bus.LEN == '0) ? LEN_W'(1) : bus.LEN;
                end
                ST_BURST: begin
                    if (bus.MEM_ACK) begin
                        r_addr   <= w_addr_inc;
                        r_remain <= r_remain - LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.address = r_addr;
    assign bus.MEM_REQ = r_req;
    assign bus.BUSY    = r_busy;
    assign bus.DONE    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mar_burst.sv
`default_nettype none
// ============================================================================
// Module   : tb_mar_burst
// Purpose  : Directed self-checking bench for mar_burst (linear or MAR_WRAP_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mar_burst;

    logic CLK;
    logic nCLR;
    int   n_pass;
    int   n_chk;

    mar_burst_if #(.ADDR_W(16), .LEN_W(3)) bus ();

    mar_burst #(.ADDR_W(16), .LEN_W(3), .WRAP_BITS(2)) u_dut (
        .CLK  (CLK),
        .nCLR (nCLR),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // DUT updates on negedge; observe and drive just after it.
    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nCLR = 1'b0; bus.nLw = 1'b0; bus.WBUS = 16'h1234;
        bus.nRd = 1'b1; bus.LEN = 3'd0; bus.MEM_ACK = 1'b0;
        step(); step();
        n_chk++; if (bus.address !== 16'h0000) $display("FAIL reset_addr: got %h want 0000", bus.address); else n_pass++;
        n_chk++; if (bus.MEM_REQ !== 1'b0) $display("FAIL reset_req: got %b want 0", bus.MEM_REQ); else n_pass++;
        n_chk++; if (bus.BUSY !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.BUSY); else n_pass++;
        n_chk++; if (bus.DONE !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.DONE); else n_pass++;
    endtask

    task automatic test_load_hold();
        nCLR = 1'b1; bus.nLw = 1'b0; bus.WBUS = 16'h1234;
        step();
        n_chk++; if (bus.address !== 16'h1234) $display("FAIL load: got %h want 1234", bus.address); else n_pass++;
        bus.nLw = 1'b1; bus.WBUS = 16'h1111;
        step();
        n_chk++; if (bus.address !== 16'h1234) $display("FAIL hold: got %h want 1234", bus.address); else n_pass++;
    endtask

    task automatic test_burst_ack();
        bus.nLw = 1'b0; bus.WBUS = 16'h0100;
        step();
        bus.nLw = 1'b1; bus.nRd = 1'b0; bus.LEN = 3'd3; bus.MEM_ACK = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            bus.nRd = 1'b1;
            n_chk++; if (bus.address !== 16'h0100 + 16'(i)) $display("FAIL burst_beat%0d_addr: got %h want %h", i, bus.address, 16'h0100 + 16'(i)); else n_pass++;
            n_chk++; if (bus.MEM_REQ !== 1'b1 || bus.DONE !== 1'b0) $display("FAIL burst_beat%0d_req: got req=%b done=%b want req=1 done=0", i, bus.MEM_REQ, bus.DONE); else n_pass++;
        end
        step();
        n_chk++; if (bus.DONE !== 1'b1 || bus.MEM_REQ !== 1'b0 || bus.BUSY !== 1'b1) $display("FAIL burst_finish: got done=%b req=%b busy=%b want 1 0 1", bus.DONE, bus.MEM_REQ, bus.BUSY); else n_pass++;
        n_chk++; if (bus.address !== 16'h0103) $display("FAIL burst_final_addr: got %h want 0103", bus.address); else n_pass++;
        step();
        n_chk++; if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) $display("FAIL burst_idle: got done=%b busy=%b want 0 0", bus.DONE, bus.BUSY); else n_pass++;
    endtask

    task automatic test_stall();
        bus.nRd = 1'b0; bus.LEN = 3'd2; bus.MEM_ACK = 1'b0;
        step();
        bus.nRd = 1'b1;
        n_chk++; if (bus.MEM_REQ !== 1'b1 || bus.address !== 16'h0103) $display("FAIL stall_start: got req=%b addr=%h want 1 0103", bus.MEM_REQ, bus.address); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++; if (bus.MEM_REQ !== 1'b1 || bus.address !== 16'h0103) $display("FAIL stall_hold%0d: got req=%b addr=%h want 1 0103", i, bus.MEM_REQ, bus.address); else n_pass++;
        end
        bus.MEM_ACK = 1'b1;
        step();
        n_chk++; if (bus.MEM_REQ !== 1'b1 || bus.address !== 16'h0104) $display("FAIL stall_beat2: got req=%b addr=%h want 1 0104", bus.MEM_REQ, bus.address); else n_pass++;
        step();
        n_chk++; if (bus.DONE !== 1'b1 || bus.address !== 16'h0105) $display("FAIL stall_done: got done=%b addr=%h want 1 0105", bus.DONE, bus.address); else n_pass++;
        step();
    endtask

    task automatic test_len_zero();
        bus.nRd = 1'b0; bus.LEN = 3'd0; bus.MEM_ACK = 1'b1;
        step();
        bus.nRd = 1'b1;
        n_chk++; if (bus.MEM_REQ !== 1'b1 || bus.address !== 16'h0105) $display("FAIL len0_beat: got req=%b addr=%h want 1 0105", bus.MEM_REQ, bus.address); else n_pass++;
        step();
        n_chk++; if (bus.DONE !== 1'b1 || bus.MEM_REQ !== 1'b0 || bus.address !== 16'h0106) $display("FAIL len0_done: got done=%b req=%b addr=%h want 1 0 0106", bus.DONE, bus.MEM_REQ, bus.address); else n_pass++;
        step();
        n_chk++; if (bus.BUSY !== 1'b0) $display("FAIL len0_idle: got busy=%b want 0", bus.BUSY); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [15:0] start;
        logic [15:0] beats [3];
        logic [15:0] fin;
`ifdef MAR_WRAP_EN
        start = 16'h0106; beats = '{16'h0106, 16'h0107, 16'h0104}; fin = 16'h0105;
`else
        start = 16'hFFFE; beats = '{16'hFFFE, 16'hFFFF, 16'h0000}; fin = 16'h0001;
`endif
        bus.nLw = 1'b0; bus.WBUS = start;
        step();
        bus.nLw = 1'b1; bus.nRd = 1'b0; bus.LEN = 3'd3; bus.MEM_ACK = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            bus.nRd = 1'b1;
            n_chk++; if (bus.address !== beats[i]) $display("FAIL wrap_beat%0d: got %h want %h", i, bus.address, beats[i]); else n_pass++;
        end
        step();
        n_chk++; if (bus.address !== fin || bus.DONE !== 1'b1) $display("FAIL wrap_final: got addr=%h done=%b want %h 1", bus.address, bus.DONE, fin); else n_pass++;
        step();
    endtask

    task automatic test_reset_mid_burst();
        bus.nLw = 1'b0; bus.WBUS = 16'h0300;
        step();
        bus.nLw = 1'b1; bus.nRd = 1'b0; bus.LEN = 3'd5; bus.MEM_ACK = 1'b1;
        step();
        bus.nRd = 1'b1;
        step();
        n_chk++; if (bus.address !== 16'h0301 || bus.MEM_REQ !== 1'b1) $display("FAIL midrst_beat2: got addr=%h req=%b want 0301 1", bus.address, bus.MEM_REQ); else n_pass++;
        nCLR = 1'b0;
        step();
        n_chk++; if (bus.address !== 16'h0000 || bus.MEM_REQ !== 1'b0 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) $display("FAIL midrst_clear: got addr=%h req=%b busy=%b done=%b want 0000 0 0 0", bus.address, bus.MEM_REQ, bus.BUSY, bus.DONE); else n_pass++;
        nCLR = 1'b1;
        step();
        n_chk++; if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) $display("FAIL midrst_after: got done=%b busy=%b want 0 0", bus.DONE, bus.BUSY); else n_pass++;
    endtask

    task automatic test_load_and_read();
        bus.nLw = 1'b0; bus.nRd = 1'b0; bus.WBUS = 16'h2000; bus.LEN = 3'd2; bus.MEM_ACK = 1'b0;
        step();
        n_chk++; if (bus.address !== 16'h2000 || bus.MEM_REQ !== 1'b1) $display("FAIL ldrd_first: got addr=%h req=%b want 2000 1", bus.address, bus.MEM_REQ); else n_pass++;
        bus.nRd = 1'b1; bus.WBUS = 16'h5555;
        step();
        n_chk++; if (bus.address !== 16'h2000) $display("FAIL ignore_lw_stall: got %h want 2000", bus.address); else n_pass++;
        bus.MEM_ACK = 1'b1;
        step();
        n_chk++; if (bus.address !== 16'h2001) $display("FAIL ignore_lw_beat: got %h want 2001", bus.address); else n_pass++;
        step();
        n_chk++; if (bus.address !== 16'h2002 || bus.DONE !== 1'b1) $display("FAIL ldrd_done: got addr=%h done=%b want 2002 1", bus.address, bus.DONE); else n_pass++;
        step();
        n_chk++; if (bus.address !== 16'h2002) $display("FAIL ignore_lw_finish: got %h want 2002", bus.address); else n_pass++;
        step();
        n_chk++; if (bus.address !== 16'h5555 || bus.BUSY !== 1'b0) $display("FAIL idle_reload: got addr=%h busy=%b want 5555 0", bus.address, bus.BUSY); else n_pass++;
        bus.nLw = 1'b1;
    endtask

    initial begin
        n_pass = 0;
        n_chk  = 0;
        test_reset();
        test_load_hold();
        test_burst_ack();
        test_stall();
        test_len_zero();
        test_wrap();
        test_reset_mid_burst();
        test_load_and_read();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
